// File: rtl/jtag_wb_burst_master.sv
// Wishbone master for the JTAG debug path: synchronised request levels drive single writes
// and multi-beat read bursts into a read FIFO. Optional JTAG_WB_TIMEOUT_EN adds a per-beat ack timeout.
module jtag_wb_burst_master #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int SELw        = DW / 8,
  parameter int BURSTw      = 4,
  parameter int RD_DEPTH    = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DW-1:0]     jtag_data_i,
  input  logic              addr_upd_i,
  input  logic              ctrl_upd_i,
  input  logic              wr_upd_i,
  input  logic              rd_req_i,
  input  logic              rd_pop_i,
  output logic [DW-1:0]     rd_data_o,
  output logic [15:0]       status_o,
  output logic [SELw-1:0]   m_sel_o,
  output logic [DW-1:0]     m_dat_o,
  output logic [AW-1:0]     m_addr_o,
  output logic [2:0]        m_cti_o,
  output logic              m_stb_o,
  output logic              m_cyc_o,
  output logic              m_we_o,
  input  logic [DW-1:0]     m_dat_i,
  input  logic              m_ack_i,
  input  logic              m_err_i
);

  localparam int PW = $clog2(RD_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2} state_t;

  // Request bit order: 0 addr, 1 ctrl, 2 wr, 3 rd, 4 pop.
  logic [4:0]                  req_lvl, top, prev_reg, pulse_reg, pulse_next;
  logic [4:0][SYNC_STAGES-1:0] sync_reg;

  assign req_lvl = {rd_pop_i, rd_req_i, wr_upd_i, ctrl_upd_i, addr_upd_i};

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_edge
      assign top[gi]        = sync_reg[gi][SYNC_STAGES-1];
      assign pulse_next[gi] = top[gi] & ~prev_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg  <= '0;
      prev_reg  <= '0;
      pulse_reg <= '0;
    end else begin
      for (int i = 0; i < 5; i++)
        sync_reg[i] <= {sync_reg[i][SYNC_STAGES-2:0], req_lvl[i]};
      prev_reg  <= top;
      pulse_reg <= pulse_next;
    end
  end

  state_t              state_reg;
  logic [AW-1:0]       addr_reg;
  logic [DW-1:0]       wdata_reg;
  logic [SELw-1:0]     sel_reg;
  logic                inc_en_reg;
  logic [BURSTw-1:0]   blen_reg, beat_reg, next_beat;
  logic                err_reg, ovr_reg, tmo_reg, stb_reg, we_reg;
  logic [2:0]          cti_reg;
  logic [PW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]         count_reg, need, free;
  logic [DW-1:0]       mem [RD_DEPTH];
  logic [3:0]          cmd;
  logic                multi_cmd, push, pop, rd_fits, burst, last_beat, tmo_hit;

  assign cmd       = pulse_reg[3:0];
  assign multi_cmd = |(cmd & (cmd - 4'd1));
  assign push      = (state_reg == RD) && m_ack_i && !m_err_i;
  assign pop       = pulse_reg[4] && (count_reg != '0);
  assign need      = (PW+1)'(blen_reg) + (PW+1)'(1);
  assign free      = (PW+1)'(RD_DEPTH) - count_reg;
  assign rd_fits   = (need <= free);
  assign burst     = inc_en_reg && (blen_reg != '0);
  assign last_beat = (beat_reg == blen_reg);
  assign next_beat = beat_reg + BURSTw'(1);

`ifdef JTAG_WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_reg;

  assign tmo_hit = (tmo_cnt_reg == TW'(TIMEOUT));

  // Restarts at every beat: zero while idle and on each ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tmo_cnt_reg <= '0;
    else if (state_reg == IDLE || m_ack_i)
      tmo_cnt_reg <= '0;
    else if (!tmo_hit)
      tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= m_dat_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      sel_reg    <= '1;
      inc_en_reg <= 1'b1;
      blen_reg   <= '0;
      beat_reg   <= '0;
      err_reg    <= 1'b0;
      ovr_reg    <= 1'b0;
      tmo_reg    <= 1'b0;
      stb_reg    <= 1'b0;
      we_reg     <= 1'b0;
      cti_reg    <= 3'b000;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (push && !pop)
        count_reg <= count_reg + (PW+1)'(1);
      else if (pop && !push)
        count_reg <= count_reg - (PW+1)'(1);

      case (state_reg)
        IDLE: begin
          if (cmd[0]) begin
            addr_reg <= jtag_data_i[AW-1:0];
            err_reg  <= 1'b0;
            ovr_reg  <= 1'b0;
            tmo_reg  <= 1'b0;
          end else if (cmd[1]) begin
            sel_reg    <= jtag_data_i[SELw-1:0];
            inc_en_reg <= jtag_data_i[SELw];
            blen_reg   <= jtag_data_i[SELw+1 +: BURSTw];
          end else if (cmd[2]) begin
            wdata_reg <= jtag_data_i;
            state_reg <= WR;
            stb_reg   <= 1'b1;
            we_reg    <= 1'b1;
            cti_reg   <= 3'b000;
          end else if (cmd[3]) begin
            if (rd_fits) begin
              state_reg <= RD;
              stb_reg   <= 1'b1;
              we_reg    <= 1'b0;
              beat_reg  <= '0;
              cti_reg   <= burst ? 3'b010 : 3'b000;
            end else begin
              ovr_reg <= 1'b1;
            end
          end
          // Losers of the priority pick flag an overrun, overriding the addr clear.
          if (multi_cmd)
            ovr_reg <= 1'b1;
        end
        default: begin
          if (|cmd)
            ovr_reg <= 1'b1;
          if (m_err_i) begin
            err_reg   <= 1'b1;
            state_reg <= IDLE;
            stb_reg   <= 1'b0;
            we_reg    <= 1'b0;
            cti_reg   <= 3'b000;
          end else if (m_ack_i) begin
            if (inc_en_reg)
              addr_reg <= addr_reg + AW'(1);
            if (state_reg == WR || last_beat) begin
              state_reg <= IDLE;
              stb_reg   <= 1'b0;
              we_reg    <= 1'b0;
              cti_reg   <= 3'b000;
            end else begin
              beat_reg <= next_beat;
              cti_reg  <= !burst ? 3'b000 : (next_beat == blen_reg) ? 3'b111 : 3'b010;
            end
          end else if (tmo_hit) begin
            err_reg   <= 1'b1;
            tmo_reg   <= 1'b1;
            state_reg <= IDLE;
            stb_reg   <= 1'b0;
            we_reg    <= 1'b0;
            cti_reg   <= 3'b000;
          end
        end
      endcase
    end
  end

  assign m_stb_o   = stb_reg;
  assign m_cyc_o   = stb_reg;
  assign m_we_o    = we_reg;
  assign m_cti_o   = cti_reg;
  assign m_sel_o   = sel_reg;
  assign m_addr_o  = addr_reg;
  assign m_dat_o   = wdata_reg;
  assign rd_data_o = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
  assign status_o  = {state_reg != IDLE, err_reg, ovr_reg, tmo_reg, 4'b0000, 8'(count_reg)};

endmodule

// File: tb/tb_jtag_wb_burst_master.sv
// Randomised bench for jtag_wb_burst_master: a queue-based model of the register file, FIFO
// and burst rules is checked against a logging Wishbone slave and the status word.
module tb_jtag_wb_burst_master;

  localparam int SYNC = 2;
  localparam int TMO  = 10;

  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] jtag_data_i = '0;
  logic        addr_upd_i = 0, ctrl_upd_i = 0, wr_upd_i = 0, rd_req_i = 0, rd_pop_i = 0;
  logic [31:0] rd_data_o, m_dat_o, m_addr_o;
  logic [15:0] status_o;
  logic [3:0]  m_sel_o;
  logic [2:0]  m_cti_o;
  logic        m_stb_o, m_cyc_o, m_we_o;
  logic [31:0] m_dat_i = '0;
  logic        m_ack_i = 0, m_err_i = 0;

  always #5 clk = ~clk;

  jtag_wb_burst_master #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .jtag_data_i(jtag_data_i),
    .addr_upd_i(addr_upd_i), .ctrl_upd_i(ctrl_upd_i), .wr_upd_i(wr_upd_i),
    .rd_req_i(rd_req_i), .rd_pop_i(rd_pop_i), .rd_data_o(rd_data_o), .status_o(status_o),
    .m_sel_o(m_sel_o), .m_dat_o(m_dat_o), .m_addr_o(m_addr_o), .m_cti_o(m_cti_o),
    .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_we_o(m_we_o), .m_dat_i(m_dat_i),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i)
  );

  int n_cmp = 0, n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Logging slave: responds after a latency, optionally erroring on the err_cd-th response.
  typedef struct {
    logic [31:0] addr; logic we; logic [2:0] cti; logic [3:0] sel;
    logic [31:0] wdat; logic [31:0] rdat; logic err;
  } beat_t;

  beat_t       log_q[$];
  beat_t       sb;
  int          fixed_lat = 0, cur_lat = 0, wait_cnt = 0, err_cd = 0;
  bit          no_resp = 0, seq_mode = 0;
  logic [31:0] seq_val = 1;

  always @(negedge clk) begin
    m_ack_i = 0;
    m_err_i = 0;
    if (reset || !(m_stb_o && m_cyc_o) || no_resp) begin
      wait_cnt = 0;
      cur_lat  = (fixed_lat < 0) ? $urandom_range(0, 3) : fixed_lat;
    end else if (wait_cnt < cur_lat) begin
      wait_cnt++;
    end else begin
      sb.addr = m_addr_o; sb.we = m_we_o; sb.cti = m_cti_o; sb.sel = m_sel_o; sb.wdat = m_dat_o;
      sb.err  = (err_cd == 1);
      if (err_cd > 0) err_cd--;
      if (seq_mode) begin sb.rdat = seq_val; seq_val++; end
      else sb.rdat = $urandom;
      m_dat_i = sb.rdat;
      if (sb.err) m_err_i = 1; else m_ack_i = 1;
      log_q.push_back(sb);
      wait_cnt = 0;
      cur_lat  = (fixed_lat < 0) ? $urandom_range(0, 3) : fixed_lat;
    end
  end

  // Reference model
  logic [31:0] md_addr, md_wdata, md_q[$];
  logic [3:0]  md_sel;
  bit          md_inc, md_err, md_ovr, md_tmo;
  int          md_blen;

  task automatic model_reset();
    md_addr = 0; md_wdata = 0; md_sel = 4'hF; md_inc = 1; md_blen = 0;
    md_err = 0; md_ovr = 0; md_tmo = 0; md_q.delete();
  endtask

  function automatic logic [31:0] head();
    return (md_q.size() != 0) ? md_q[0] : 32'h0;
  endfunction

  task automatic check_state(input string tag);
    logic [15:0] exp_st;
    exp_st = {1'b0, md_err, md_ovr, md_tmo, 4'b0, 8'(md_q.size())};
    chk({tag, "_status"}, status_o, exp_st);
    chk({tag, "_addr"}, m_addr_o, md_addr);
    chk({tag, "_sel"}, m_sel_o, md_sel);
    chk({tag, "_wdat"}, m_dat_o, md_wdata);
    chk({tag, "_rdata"}, rd_data_o, head());
    chk({tag, "_nobus"}, log_q.size(), 0);
    $display("txn %-8s status=%04h addr=%08h head=%08h", tag, status_o, m_addr_o, rd_data_o);
  endtask

  task automatic check_wr();
    beat_t b;
    chk("wr_beats", log_q.size(), 1);
    if (log_q.size() > 0) begin
      b = log_q[0];
      chk("wr_addr", b.addr, md_addr);
      chk("wr_we", b.we, 1);
      chk("wr_cti", b.cti, 0);
      chk("wr_sel", b.sel, md_sel);
      chk("wr_dat", b.wdat, md_wdata);
      if (b.err) md_err = 1;
      else if (md_inc) md_addr++;
    end
    log_q.delete();
  endtask

  task automatic check_rd();
    beat_t b;
    int n = md_blen + 1;
    logic [2:0] ecti;
    for (int i = 0; i < log_q.size(); i++) begin
      if (i >= n) break;
      b = log_q[i];
      ecti = (md_blen == 0 || !md_inc) ? 3'd0 : (i == md_blen) ? 3'd7 : 3'd2;
      chk("rd_addr", b.addr, md_addr);
      chk("rd_we", b.we, 0);
      chk("rd_cti", b.cti, ecti);
      chk("rd_sel", b.sel, md_sel);
      if (b.err) begin
        md_err = 1;
        n = i + 1;
      end else begin
        md_q.push_back(b.rdat);
        if (md_inc) md_addr++;
      end
    end
    chk("rd_beats", log_q.size(), n);
    log_q.delete();
  endtask

  task automatic set_level(input int idx, input logic v);
    case (idx)
      0: addr_upd_i = v;
      1: ctrl_upd_i = v;
      2: wr_upd_i   = v;
      3: rd_req_i   = v;
      default: rd_pop_i = v;
    endcase
  endtask

  task automatic wait_idle();
    int c = 0;
    while (m_stb_o && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("idle_wait", m_stb_o, 0);
  endtask

  task automatic send(input int idx, input logic [31:0] d, input bit bus);
    @(negedge clk);
    jtag_data_i = d;
    set_level(idx, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    if (bus) chk("stb_early", m_stb_o, 0);
    @(posedge clk);
    #1;
    if (bus) chk("stb_rise", m_stb_o, 1);
    wait_idle();
    set_level(idx, 1'b0);
    repeat (SYNC + 2) @(negedge clk);
  endtask

  task automatic do_addr(input logic [31:0] d);
    send(0, d, 0);
    md_addr = d; md_err = 0; md_ovr = 0; md_tmo = 0;
    check_state("addr");
  endtask

  task automatic do_ctrl(input logic [31:0] d);
    send(1, d, 0);
    md_sel = d[3:0]; md_inc = d[4]; md_blen = int'(d[8:5]);
    check_state("ctrl");
  endtask

  task automatic do_wr(input logic [31:0] d);
    send(2, d, 1);
    md_wdata = d;
    check_wr();
    check_state("wr");
  endtask

  task automatic do_rd();
    bit fits;
    fits = (16 - md_q.size()) >= (md_blen + 1);
    send(3, jtag_data_i, fits);
    if (fits) check_rd();
    else md_ovr = 1;
    check_state(fits ? "rd" : "rd_rej");
  endtask

  task automatic do_pop();
    @(negedge clk);
    rd_pop_i = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("pop_pre", rd_data_o, head());
    @(posedge clk);
    #1;
    if (md_q.size() != 0) void'(md_q.pop_front());
    chk("pop_post", rd_data_o, head());
    @(negedge clk);
    rd_pop_i = 0;
    repeat (SYNC + 2) @(negedge clk);
    check_state("pop");
  endtask

  task automatic drain();
    while (md_q.size() != 0) do_pop();
  endtask

  initial begin
    logic [31:0] d;
    int cnt;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_status", status_o, 0);
    chk("rst_stb", m_stb_o, 0);
    chk("rst_cyc", m_cyc_o, 0);
    chk("rst_we", m_we_o, 0);
    chk("rst_cti", m_cti_o, 0);
    chk("rst_sel", m_sel_o, 4'hF);
    chk("rst_addr", m_addr_o, 0);
    chk("rst_dat", m_dat_o, 0);
    chk("rst_rdata", rd_data_o, 0);
    reset = 0;
    repeat (2) @(negedge clk);

    // Single write with a 3-cycle ack.
    do_addr(32'h100);
    fixed_lat = 3;
    do_wr(32'hDEADBEEF);
    chk("t1_addr", m_addr_o, 32'h101);

    // Incrementing burst of 4 returning 1..4.
    fixed_lat = 0;
    do_ctrl(32'h7F);
    do_addr(32'h20);
    seq_mode = 1; seq_val = 1;
    do_rd();
    seq_mode = 0;
    chk("t2_count", status_o[7:0], 4);
    drain();
    chk("t2_empty", rd_data_o, 0);

    // Error on the third beat.
    do_addr(32'h20);
    err_cd = 3;
    do_rd();
    err_cd = 0;
    chk("t3_err", status_o[14], 1);
    chk("t3_count", status_o[7:0], 2);
    chk("t3_addr", m_addr_o, 32'h22);
    drain();

    // Write request while a slow read is in progress.
    do_addr(32'h300);
    do_ctrl(32'h3F);
    fixed_lat = 30;
    @(negedge clk);
    rd_req_i = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("a_busy", status_o[15], 1);
    @(negedge clk);
    wr_upd_i = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("a_still_busy", status_o[15], 1);
    wait_idle();
    rd_req_i = 0; wr_upd_i = 0;
    repeat (SYNC + 2) @(negedge clk);
    fixed_lat = 0;
    check_rd();
    md_ovr = 1;
    check_state("conflict_a");
    drain();

    // Read rejected for lack of FIFO space (14 of 16 held, 4 requested).
    do_addr(32'h400);
    do_ctrl(32'h1BF);
    do_rd();
    chk("b_fill", status_o[7:0], 14);
    do_ctrl(32'h7F);
    do_rd();
    chk("b_ovr", status_o[13], 1);
    drain();
    do_addr(32'h0);
    do_pop();

    // Simultaneous addr and wr pulses.
    @(negedge clk);
    jtag_data_i = 32'h500;
    addr_upd_i = 1; wr_upd_i = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("c_nostb", m_stb_o, 0);
    @(negedge clk);
    addr_upd_i = 0; wr_upd_i = 0;
    repeat (SYNC + 2) @(negedge clk);
    md_addr = 32'h500; md_err = 0; md_tmo = 0; md_ovr = 1;
    check_state("conflict_c");

    // Randomised mix against the model.
    fixed_lat = -1;
    for (int it = 0; it < 40; it++) begin
      d = $urandom;
      case ($urandom_range(0, 9))
        0, 1: begin
          if ($urandom_range(0, 3) == 0) d = 32'hFFFF_FFFE;
          do_addr(d);
        end
        2, 3: begin
          d[8:5] = 4'($urandom_range(0, 7));
          do_ctrl(d);
        end
        4, 5: begin
          if ($urandom_range(0, 4) == 0) err_cd = 1;
          do_wr(d);
        end
        6, 7: begin
          if ($urandom_range(0, 3) == 0) err_cd = $urandom_range(1, 4);
          do_rd();
        end
        default: begin
          cnt = $urandom_range(1, 4);
          for (int k = 0; k < cnt; k++) do_pop();
        end
      endcase
      err_cd = 0;
    end
    fixed_lat = 0;
    drain();

`ifdef JTAG_WB_TIMEOUT_EN
    do_addr(32'h40);
    do_ctrl(32'h1F);
    no_resp = 1;
    @(negedge clk);
    rd_req_i = 1;
    cnt = 0;
    while (!m_stb_o && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    cnt = 0;
    while (m_stb_o && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    chk("tmo_len", cnt, TMO + 1);
    rd_req_i = 0;
    no_resp = 0;
    repeat (SYNC + 2) @(negedge clk);
    md_err = 1; md_tmo = 1;
    check_state("timeout");
    do_addr(32'h41);
`endif

    // Asynchronous reset in the middle of a burst.
    do_ctrl(32'h7F);
    do_addr(32'h600);
    fixed_lat = 5;
    @(negedge clk);
    rd_req_i = 1;
    repeat (12) @(posedge clk);
    #1;
    chk("r_busy", status_o[15], 1);
    chk("r_count", status_o[7:0], 1);
    #3;
    reset = 1;
    #1;
    chk("r_stb", m_stb_o, 0);
    chk("r_cyc", m_cyc_o, 0);
    chk("r_status", status_o, 0);
    chk("r_rdata", rd_data_o, 0);
    chk("r_sel", m_sel_o, 4'hF);
    rd_req_i = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    model_reset();
    log_q.delete();
    fixed_lat = 0;
    repeat (2) @(negedge clk);
    check_state("after_rst");
    do_addr(32'h7);
    do_wr(32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/jtag_wb_burst_master.md
# jtag_wb_burst_master

Clock-domain Wishbone master engine for the JTAG debug path, successor to the single-beat JTAG-to-Wishbone bridge. It accepts level-type request strobes and a shared data word from the tck-domain JTAG controller, synchronises them into clk, and issues single writes or multi-beat read bursts. Configuration fields are byte select, auto-increment and burst length. Read data is buffered in a FIFO, and timeouts, bus errors and protocol overruns are reported in a status word. It sits between the vjtag controller and the SoC Wishbone interconnect.

## Interface
- DW, 32: data width, multiple of 8.
- AW, 32: word-address width.
- SELw, DW/8: byte-select width.
- BURSTw, 4: burst-length field width; beats = field+1.
- RD_DEPTH, 16: read FIFO depth, power of 2, ≥ 2^BURSTw.
- SYNC_STAGES, 2: synchroniser flops per request input, ≥2.
- TIMEOUT, 255: cycles waited per beat for ack/err.
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- jtag_data_i  in  DW  tck-domain data word, stable while any request level is high.
- addr_upd_i, ctrl_upd_i, wr_upd_i, rd_req_i, rd_pop_i  in  1 each  tck-domain request levels.
- rd_data_o  out  DW  FIFO head, 0 when empty.
- status_o  out  16  {busy, err, ovr, timeout, 4'b0, fifo_count[7:0]}; unused count bits are 0.
- m_sel_o  out  SELw  Wishbone byte select.
- m_dat_o  out  DW  Wishbone write data.
- m_addr_o  out  AW  Wishbone address.
- m_cti_o  out  3  Wishbone cycle type.
- m_stb_o  out  1  Wishbone strobe.
- m_cyc_o  out  1  Wishbone cycle.
- m_we_o  out  1  Wishbone write enable.
- m_dat_i  in  DW  Wishbone read data.
- m_ack_i  in  1  Wishbone acknowledge.
- m_err_i  in  1  Wishbone error.

## Operation
- Each request level passes SYNC_STAGES flops plus a rising-edge detect, producing a 1-cycle pulse. jtag_data_i is sampled on the pulse.
- Registers and reset values:
  - addr = 0.
  - wdata = 0.
  - sel = all ones.
  - inc_en = 1.
  - blen = 0.
- addr pulse:
  - addr ← data[AW-1:0].
  - Clears err, ovr and timeout.
- ctrl pulse:
  - sel ← data[SELw-1:0].
  - inc_en ← data[SELw].
  - blen ← data[SELw+1 +: BURSTw].
- wr pulse: wdata ← data, then go to WR.
- rd pulse: go to RD only if FIFO free space ≥ blen+1. Otherwise set ovr and ignore the request.
- pop pulse: drop the FIFO head. A pop when empty is ignored and does not set ovr.
- In IDLE, at most one of addr/ctrl/wr/rd is accepted per cycle, priority addr > ctrl > wr > rd. Every other simultaneous pulse sets ovr.
- Any addr/ctrl/wr/rd pulse while busy is ignored and sets ovr. Pop is always served.
- FSM states: IDLE, WR, RD.
  - IDLE: stb = cyc = 0.
  - WR:
    - Single beat: stb = cyc = we = 1, cti = 000.
    - On ack: if inc_en, addr += 1; go to IDLE.
  - RD:
    - stb = cyc = 1, we = 0, with a beat counter.
    - cti = 000 if blen = 0 or inc_en = 0.
    - Otherwise cti = 010, and 111 on the last beat.
    - Each ack pushes m_dat_i into the FIFO and increments addr if inc_en.
    - After the last ack, go to IDLE.
- Beat termination:
  - m_err_i in WR/RD: set err, abort to IDLE, no address increment, no FIFO push for that beat. Beats already pushed are kept.
  - ack and err in the same cycle: err wins.
- Address arithmetic wraps modulo 2^AW.
- m_sel_o = sel, m_addr_o = addr, m_dat_o = wdata.
- busy = (state ≠ IDLE).
- Reset mid-burst: all state cleared immediately, stb/cyc low asynchronously, FIFO emptied.

## Timing
- Request level rise to pulse: SYNC_STAGES+1 clk.
- stb rises the cycle after the pulse.
- Burst beats are back-to-back: stb stays high and addr/cti update the cycle after each ack.
- stb/cyc fall the cycle after the terminating ack/err/timeout.
- FIFO push is visible on rd_data_o and fifo_count the cycle after the ack.
- Pop takes effect the cycle after the pop pulse.
- All outputs are 0 in reset, except m_sel_o = all ones.

## Configuration
- JTAG_WB_TIMEOUT_EN defined:
  - A per-beat counter resets on stb rise and on each ack.
  - Reaching TIMEOUT cycles with no ack/err aborts to IDLE and sets timeout and err.
- Not defined: no counter; the engine waits indefinitely for ack/err, and the timeout bit reads 0.

## Test plan
- addr pulse 0x100, wr pulse 0xDEADBEEF, ack after 3 cycles → one beat at 0x100 with we = 1, sel = F, cti = 000; addr becomes 0x101.
- ctrl pulse (blen = 3, inc_en = 1), addr 0x20, rd pulse, slave returns 1..4 → cti 010,010,010,111; addresses 0x20–0x23; fifo_count = 4; four pops give 1,2,3,4, then rd_data_o = 0.
- Read burst of 4 with err on beat 3 → err = 1, fifo_count = 2, addr = 0x22, busy = 0 next cycle.
- JTAG_WB_TIMEOUT_EN with TIMEOUT = 10 and no slave response → stb drops 11 cycles after rising; timeout = err = 1. A following addr pulse clears both flags.
- Back-to-back conflicts:
  - wr pulse during a busy read, or rd pulse with FIFO holding 14 of 16 and blen = 3 → ovr = 1, no bus activity.
  - Simultaneous addr and wr pulses in IDLE → addr loaded, ovr = 1, no write issued.
- Reset asserted mid-burst → stb/cyc/status cleared the same cycle; FIFO empty.
